// File: rtl/uop_block_sched_pkg.sv
// Shared types and helpers for the uop_block_sched requester/datapath scheduler.
package uop_block_sched_pkg;

   // Widest requester ID supported (NREQ up to 16).
   localparam int unsigned SchedIdWMax = 4;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic                   v;
      logic [SchedIdWMax-1:0] id;
   } sched_tag_t;

endpackage

// File: rtl/uop_block_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward and advances past each accepted grant.
module rr_arbiter
   import uop_block_sched_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = id_width(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant_oh,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic          found;
   int unsigned   idx;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = (32'(ptr_q) + off) % N;
         if (!found && req[idx[IW-1:0]]) begin
            found                  = 1'b1;
            grant_idx              = idx[IW-1:0];
            grant_oh[idx[IW-1:0]]  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/uop_block_sched.sv
// Shares one fixed-latency datapath among NREQ requesters and steers tagged results back.
module uop_block_sched
   import uop_block_sched_pkg::*;
#(
   parameter  int unsigned NREQ    = 4,
   parameter  int unsigned W       = 64,
   parameter  int unsigned LAT     = 2,
   parameter  int unsigned MAX_OUT = 2,
   localparam int unsigned IDW     = id_width(NREQ),
   localparam int unsigned SW      = $clog2(W),
   localparam int unsigned CW      = $clog2(MAX_OUT + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid_i,
   input  logic [NREQ*W-1:0]  req_src_i,
   input  logic [NREQ*SW-1:0] req_shamt_i,
   output logic [NREQ-1:0]    req_ready_o,
   input  logic               flush_i,
   output logic [W-1:0]       dp_src_o,
   output logic [SW-1:0]      dp_shamt_o,
   output logic               dp_valid_o,
   input  logic [W-1:0]       dp_dst_i,
   output logic               rsp_valid_o,
   output logic [IDW-1:0]     rsp_id_o,
   output logic [W-1:0]       rsp_data_o,
   output logic [CW-1:0]      inflight_o
);

   logic [NREQ-1:0] grant_oh;
   logic [IDW-1:0]  grant_idx;
   logic            transfer;
   logic            retire;
   logic            room;
   sched_tag_t      tag_q [LAT];
   sched_tag_t      tag_d [LAT];
   logic [CW-1:0]   inflight_q, inflight_d;

   rr_arbiter #(
      .N (NREQ)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid_i),
      .advance   (transfer),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx)
   );

   // A retiring op frees its credit in the same cycle, so a full pipe still issues back-to-back.
   always_comb begin
      retire      = tag_q[LAT-1].v;
      room        = (32'(inflight_q) < MAX_OUT) || retire;
      transfer    = rst_n && !flush_i && room && (|req_valid_i);
      req_ready_o = transfer ? grant_oh : '0;
      dp_valid_o  = transfer;
      dp_src_o    = transfer ? req_src_i[32'(grant_idx)*W +: W] : '0;
      dp_shamt_o  = transfer ? req_shamt_i[32'(grant_idx)*SW +: SW] : '0;
   end

   always_comb begin
      rsp_valid_o = retire && !flush_i;
      rsp_id_o    = rsp_valid_o ? IDW'(tag_q[LAT-1].id) : '0;
      rsp_data_o  = rsp_valid_o ? dp_dst_i : '0;
      inflight_o  = inflight_q;
   end

   always_comb begin
      tag_d[0].v  = transfer;
      tag_d[0].id = SchedIdWMax'(grant_idx);
      for (int unsigned k = 1; k < LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end
      if (flush_i) begin
         for (int unsigned k = 0; k < LAT; k++) begin
            tag_d[k].v = 1'b0;
         end
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      if (transfer && !retire) begin
         inflight_d = inflight_q + 1'b1;
      end else if (!transfer && retire) begin
         inflight_d = inflight_q - 1'b1;
      end
      if (flush_i) begin
         inflight_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < LAT; k++) begin
            tag_q[k] <= '0;
         end
         inflight_q <= '0;
      end else begin
         for (int unsigned k = 0; k < LAT; k++) begin
            tag_q[k] <= tag_d[k];
         end
         inflight_q <= inflight_d;
      end
   end

   a_inflight_max: assert property (@(posedge clk) disable iff (!rst_n)
      32'(inflight_q) <= MAX_OUT);
   a_inflight_nounder: assert property (@(posedge clk) disable iff (!rst_n)
      retire |-> (inflight_q != '0));

endmodule

// File: doc/uop_block_sched.md
Name: uop_block_sched

Overview:
- Shares one uop_block_wrap datapath instance among NREQ requesters.
- Round-robin arbitration selects one request per cycle and drives the datapath src/shamt inputs.
- Tracks the requester ID of each in-flight operation through a fixed-latency tag pipe and steers each result back as a tagged response.
- Sits between requester ports (e.g. per-lane issue logic) and the uop_block_wrap instance; the datapath itself is not instantiated here.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 64, datapath width; must equal the datapath W.
- LAT, 2, cycles from the issue edge to a valid dp_dst_i. Must equal 1 (wrap input register) + the datapath pipeline latency.
- MAX_OUT, 2, maximum in-flight operations (1..LAT); values below LAT throttle issue.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NREQ  per-requester request valid.
- req_src_i  in  NREQ*W  packed operands; requester i uses slice [i*W +: W].
- req_shamt_i  in  NREQ*$clog2(W)  packed shift amounts.
- req_ready_o  out  NREQ  one-hot accept; a request transfers when valid&ready.
- flush_i  in  1  discard all in-flight operations.
- dp_src_o  out  W  operand to the datapath src_i.
- dp_shamt_o  out  $clog2(W)  to the datapath shamt_i.
- dp_valid_o  out  1  high in the cycle an operand is presented.
- dp_dst_i  in  W  datapath dst_o.
- rsp_valid_o  out  1  result valid; no backpressure, so the requester must sink it.
- rsp_id_o  out  $clog2(NREQ)  ID of the requester that owns the result.
- rsp_data_o  out  W  result data.
- inflight_o  out  $clog2(MAX_OUT+1)  current in-flight count.

Behaviour:
- Reset (async assert, sync release):
  - rr pointer = 0; tag pipe valids = 0; inflight = 0.
  - All outputs 0: dp_src_o, dp_shamt_o, dp_valid_o, rsp_*, inflight_o.
  - A reset mid-operation drops every in-flight result; no rsp_valid_o follows reset release.
- Arbitration (combinational):
  - Grant goes to the first i with req_valid_i[i], searching pointer, pointer+1, ... modulo NREQ.
  - req_ready_o[grant] = 1 only when (inflight < MAX_OUT or a retire occurs this cycle) and !flush_i. All other ready bits are 0.
  - Ready never asserts for a requester whose valid is low.
- Issue:
  - On a transfer, pointer <= grant+1 with wrap (NREQ-1 -> 0).
  - With no transfer, pointer holds.
- Datapath drive:
  - dp_src_o, dp_shamt_o and dp_valid_o are combinational from the granted request, masked by the transfer condition.
  - dp_src_o and dp_shamt_o are 0 when no transfer occurs.
- Tag pipe:
  - LAT-deep shift register of {valid, id}.
  - Stage 0 loads {transfer, grant}. At the last stage: rsp_valid_o = valid, rsp_id_o = id, rsp_data_o = dp_dst_i.
  - This gives issue at edge t and response visible in the cycle after edge t+LAT-1, i.e. LAT cycles of latency. Back-to-back issue is bubble-free.
  - rsp_data_o is 0 when rsp_valid_o is 0.
- In-flight counter:
  - +1 on transfer, -1 on retire (last-stage valid); simultaneous events net to 0.
  - Never exceeds MAX_OUT and never underflows; assertions cover both.
- Flush:
  - In the flush cycle: all tag valids cleared, inflight <= 0, no issue, rsp_valid_o forced 0 combinationally.
  - Pointer unchanged.
  - Results already inside the datapath exit unflagged and are ignored.
- Input stability: a request held valid without ready may change operands freely; this block has no requirement on that.

Decomposition:
- uop_pkg gains a localparam helper for ID width ($clog2 of NREQ, minimum 1) and typedef sched_tag_t {logic v; logic [IDW-1:0] id;}.
- Sub-module rr_arbiter:
  - Parameter N; inputs req, advance; outputs grant_oh and grant_idx.
  - Owns the pointer register; reset is async active-low.
- The tag pipe and counter stay in the top level.

Test Plan:
- Single request: reset, then req_valid_i=0001 with src=0x1234, one cycle. Required: dp_valid_o pulses once; LAT=2 cycles later rsp_valid_o=1, rsp_id_o=0, rsp_data_o equals the dp_dst_i model; inflight returns to 0.
- Round-robin fairness: all four valid continuously for 8 cycles, MAX_OUT=LAT. Required: grant order 0,1,2,3,0,1,2,3, every cycle issuing; responses carry IDs in the same order with no bubbles.
- Credit throttle: MAX_OUT=1, LAT=2, req 0 held valid. Required: issue every other cycle; inflight_o never exceeds 1; ready is 0 on non-issue cycles.
- Pointer wrap and skip: only requesters 3 and 1 valid, pointer=2. Required: grant 3, then 1, then 3.
- Flush mid-flight: issue IDs 0 then 1 on consecutive cycles, assert flush_i the next cycle. Required: no rsp_valid_o for either ID; inflight_o=0; no ready during the flush cycle; the next request issues normally.
- Async reset mid-operation: drop rst_n between clock edges with 2 in flight. Required: all outputs 0 immediately; after release, no stray responses and pointer=0.
